// File: rtl/obf_key_pkg.sv
// Shared types and constants for the obfuscation key loader.
// Site mode encodings, loader state enum and reset key helper.
package obf_key_pkg;

    localparam logic [1:0] OBF_PASS = 2'b00;
    localparam logic [1:0] OBF_INV  = 2'b01;
    localparam logic [1:0] OBF_C1   = 2'b10;
    localparam logic [1:0] OBF_C0   = 2'b11;

    localparam int MAX_KEY_W = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PAR    = 3'd2,
        CHECK  = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } obf_ld_state_t;

    // All-ones key of the requested width: every site forced to constant 0.
    function automatic logic [MAX_KEY_W-1:0] obf_reset_key(input int key_w);
        logic [MAX_KEY_W-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_KEY_W; i++) begin
            if (i < key_w) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/obf_key_shift.sv
// Shadow register, bit counter and running parity for one key frame.
// Ports: clk/rst_n, clr, shift_en (key bit), par_en (parity bit), bit_in;
//        shadow (collected key), last (next shift is final), parity (XOR).
module obf_key_shift #(
    parameter int KEY_W = 10,
    localparam int CNT_W = $clog2(KEY_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             par_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             last,
    output logic             parity
);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(KEY_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            shadow <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else begin
            if (shift_en) begin
                shadow[cnt] <= bit_in;
                cnt         <= cnt + 1'b1;
            end
            // Parity bit joins the accumulator but never the shadow.
            if (shift_en || par_en) parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader: collects a key frame, checks it, commits it to D.
// Ports: CK/RN, LOAD_START, KEY_SI/KEY_VLD/KEY_RDY stream, D key bus,
//        KEY_LOCKED, ERR. Macro OBF_KEY_PARITY_EN adds a trailing parity bit.
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int NUM_SITES = 5,
    parameter int KEY_W     = 2 * NUM_SITES
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             LOAD_START,
    input  logic             KEY_SI,
    input  logic             KEY_VLD,
    output logic             KEY_RDY,
    output logic [KEY_W-1:0] D,
    output logic             KEY_LOCKED,
    output logic             ERR
);

    localparam logic [MAX_KEY_W-1:0] RST_FULL = obf_reset_key(KEY_W);
    localparam logic [KEY_W-1:0]     RST_KEY  = RST_FULL[KEY_W-1:0];

    obf_ld_state_t state_q, state_d;

    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] d_q;
    logic             last, parity;
    logic             rdy_q, locked_q, err_q;
    logic             xfer, clr, shift_en, par_en, commit, fail;

    // rdy_q mirrors SHIFT/PAR, so this is a registered handshake.
    assign xfer = KEY_VLD && rdy_q;

    obf_key_shift #(.KEY_W(KEY_W)) u_shift (
        .clk      (CK),
        .rst_n    (RN),
        .clr      (clr),
        .shift_en (shift_en),
        .par_en   (par_en),
        .bit_in   (KEY_SI),
        .shadow   (shadow),
        .last     (last),
        .parity   (parity)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        commit   = 1'b0;
        fail     = 1'b0;
        unique case (state_q)
            IDLE, LOCKED, FAIL: begin
                if (LOAD_START) begin
                    state_d = SHIFT;
                    clr     = 1'b1;
                end
            end
            SHIFT: begin
                if (LOAD_START) begin
                    clr = 1'b1;
                end else if (xfer) begin
                    shift_en = 1'b1;
                    if (last) begin
`ifdef OBF_KEY_PARITY_EN
                        state_d = PAR;
`else
                        state_d = CHECK;
`endif
                    end
                end
            end
            PAR: begin
                if (LOAD_START) begin
                    state_d = SHIFT;
                    clr     = 1'b1;
                end else if (xfer) begin
                    par_en  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
`ifdef OBF_KEY_PARITY_EN
                if (!parity) begin
                    commit  = 1'b1;
                    state_d = LOCKED;
                end else begin
                    fail    = 1'b1;
                    state_d = FAIL;
                end
`else
                commit  = 1'b1;
                state_d = LOCKED;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            d_q      <= RST_KEY;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= (state_d == SHIFT) || (state_d == PAR);
            if (commit) begin
                d_q      <= shadow;
                locked_q <= 1'b1;
            end
            if (clr)       err_q <= 1'b0;
            else if (fail) err_q <= 1'b1;
        end
    end

    assign D          = d_q;
    assign KEY_LOCKED = locked_q;
    assign KEY_RDY    = rdy_q;
`ifdef OBF_KEY_PARITY_EN
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule
